adaptive_background_mc: RTL and testbench
=========================================

// Module: adaptive_background_mc
// PURPOSE
//  Multi-channel successor to the grayscale adaptive background subtractor.
//  Compares NUM_CH-channel live pixels against the background RAM and flags foreground.
//  Writes the updated background back to the RAM through a 3-stage pipeline.
//  Adds a frame-level FSM (initial copy, warm-up, run, global relearn) and a per-frame foreground pixel count.
// PARAMETERS
//  ADDR_WIDTH     17  background RAM address width
//  PIXEL_WIDTH    8   bits per channel
//  NUM_CH         3   channels per pixel (1..4)
//  SHIFT_LG2      3   RUN background learning rate 1/2^n
//  FG_SHIFT_LG2   7   RUN foreground learning rate 1/2^n
//  WARM_SHIFT_LG2 1   WARM/RELEARN learning rate 1/2^n
//  WARMUP_FRAMES  8   WARM frames after COPY (0 = go straight to RUN)
//  Derived: PW=NUM_CH*PIXEL_WIDTH, TH_W=PIXEL_WIDTH+2, CNT_W=ADDR_WIDTH+1
// PORTS
//  clk             in  1           system clock
//  rst_n           in  1           asynchronous, active-low reset
//  enable          in  1           pipeline advance; low = full stall
//  addr_in         in  ADDR_WIDTH  pixel address
//  live_pixel_in   in  PW          live pixel, ch0 in LSBs
//  bg_pixel_in     in  PW          background RAM read data for addr_in
//  active_in       in  1           valid pixel this cycle
//  frame_start_in  in  1           first pixel of frame (qualified by active_in)
//  load_frame      in  1           request COPY, sampled at frame start
//  fg_mode_in      in  1           0: any-channel compare; 1: sum-of-abs compare
//  threshold_in    in  TH_W        foreground threshold
//  global_limit_in in  CNT_W       relearn trigger count (0 = disabled)
//  bg_wr_addr      out ADDR_WIDTH  background write address
//  bg_wr_data      out PW          background write data
//  bg_wr_en        out 1           background write strobe
//  fg_pixel_out    out PW          live pixel if foreground, else 0
//  foreground_flag out 1           foreground decision
//  out_valid       out 1           outputs carry a valid pixel
//  fg_count_out    out CNT_W       foreground count of the previous frame
//  fg_count_valid  out 1           1-cycle pulse when fg_count_out updates
//  state_out       out 3           0 IDLE, 1 COPY, 2 WARM, 3 RUN, 4 RELEARN
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, pipeline valid bits 0.
//  Pipeline: p1 latches inputs; p2 computes deltas; p3 registers outputs.
//    Input to output latency is 3 enabled cycles.
//    enable=0 holds all state; bg_wr_en = en_p3 & enable (no duplicate writes).
//  FSM updates only on an enabled cycle with active_p1 & frame_start_p1.
//    The pixel in p1 on that cycle uses the NEXT state (eff_state).
//    Priority 1: load_frame_p1 -> COPY, warm_cnt := 0.
//    IDLE -> COPY.  COPY -> WARM, or RUN if WARMUP_FRAMES=0.
//    WARM: warm_cnt++ each frame; -> RUN once warm_cnt reaches WARMUP_FRAMES.
//    RUN -> RELEARN if global_limit_in!=0 and completed-frame count > global_limit_in.
//    RELEARN -> RUN at the next frame start (exactly one frame).
//  Per channel c: diff = {0,live}-{0,bg}, signed PIXEL_WIDTH+1 bits.
//    Compute abs(diff) for each channel.
//    fg_raw = mode0: any abs_c > thr; mode1: sum(abs_c) > thr (sum is TH_W bits, no overflow for NUM_CH<=4).
//  foreground = fg_raw & eff_state==RUN & active.
//  Write data per channel, by state:
//    IDLE: no write.  COPY: live.
//    WARM/RELEARN: bg + (diff>>>WARM_SHIFT_LG2).
//    RUN: bg + (diff>>>(fg ? FG_SHIFT_LG2 : SHIFT_LG2)).
//    Arithmetic shift floors, so -1>>>n stays -1. Results saturate to [0, 2^PIXEL_WIDTH-1] per channel.
//  bg_wr_en = active_p3 & state_p3!=IDLE.
//  out_valid = active_p3. Outputs are 0 when not active.
//  Foreground counter (p1 timing) increments on active_p1 & foreground and saturates at 2^CNT_W-1.
//    On frame start it latches into fg_count_out, pulses fg_count_valid, and restarts at that pixel's decision (0/1).
//  frame_start_in without active_in is ignored. load_frame mid-frame takes effect at the next frame start.
//  Reset mid-frame returns to IDLE; no writes occur until the next frame start.
// TESTING
//  Reset, then frame 0 with live=0x10/0x20/0x30 and bg=0 -> bg_wr_data=live and fg=0; state_out 1 then 2.
//  WARM, live=0x80, bg=0x40, shift 1 -> write 0x60 per channel.
//    After 8 WARM frames, state_out=3.
//  RUN, thr=0x20, mode0, live ch1=0x90, bg=0x60 -> fg=1, fg_pixel=live; write ch1=0x60+0x30>>>7=0x60.
//    Mode1 with 3x0x0C diffs and thr=0x20 -> fg=1.
//  RUN, live=0, bg=3, shift 3 -> write 2 (floor), never below 0.
//    live=0xFF, bg=0xFE -> write at most 0xFF.
//  global_limit_in=10 with 11 fg pixels in a frame -> fg_count_out=11 pulse, state 4 for one frame, then 3.
//    load_frame mid-frame -> COPY at the next frame start.
//  enable low for 5 cycles mid-stream -> outputs frozen, bg_wr_en=0.
//    rst_n pulse mid-frame -> all outputs 0, IDLE.

Source files
------------

// File: rtl/adaptive_background_mc.sv
// Multi-channel adaptive background subtractor: a 3-stage compare/update pipeline
// writing the learned background back to RAM, a frame-level learning FSM and a per-frame foreground count.
module adaptive_background_mc #(
    parameter int ADDR_WIDTH     = 17,
    parameter int PIXEL_WIDTH    = 8,
    parameter int NUM_CH         = 3,
    parameter int SHIFT_LG2      = 3,
    parameter int FG_SHIFT_LG2   = 7,
    parameter int WARM_SHIFT_LG2 = 1,
    parameter int WARMUP_FRAMES  = 8,
    localparam int PW    = NUM_CH * PIXEL_WIDTH,
    localparam int TH_W  = PIXEL_WIDTH + 2,
    localparam int CNT_W = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [PW-1:0]         live_pixel_in,
    input  logic [PW-1:0]         bg_pixel_in,
    input  logic                  active_in,
    input  logic                  frame_start_in,
    input  logic                  load_frame,
    input  logic                  fg_mode_in,
    input  logic [TH_W-1:0]       threshold_in,
    input  logic [CNT_W-1:0]      global_limit_in,
    output logic [ADDR_WIDTH-1:0] bg_wr_addr,
    output logic [PW-1:0]         bg_wr_data,
    output logic                  bg_wr_en,
    output logic [PW-1:0]         fg_pixel_out,
    output logic                  foreground_flag,
    output logic                  out_valid,
    output logic [CNT_W-1:0]      fg_count_out,
    output logic                  fg_count_valid,
    output logic [2:0]            state_out
);
    localparam int DW   = PIXEL_WIDTH + 1;
    localparam int WC_W = $clog2(WARMUP_FRAMES + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COPY    = 3'd1,
        S_WARM    = 3'd2,
        S_RUN     = 3'd3,
        S_RELEARN = 3'd4
    } state_t;

    state_t state, next_state, state_p2;
    logic [WC_W-1:0] warm_cnt, next_warm, warm_inc;
    logic [CNT_W-1:0] fg_cnt, limit_p1;
    logic load_pend;

    // p1 stage registers
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [PW-1:0]         live_p1, bg_p1;
    logic                  active_p1, fs_p1, load_p1, mode_p1;
    logic [TH_W-1:0]       thr_p1;

    // p2 stage registers
    logic [ADDR_WIDTH-1:0] addr_p2;
    logic [PW-1:0]         live_p2, bg_p2;
    logic [NUM_CH*DW-1:0]  diff_p1, diff_p2;
    logic                  active_p2, fg_p2;

    logic en_p3;
    logic frame_evt, fg_raw, fg_p1;
    logic [NUM_CH-1:0] over_thr;
    logic [NUM_CH:0][TH_W-1:0] abs_sum;
    logic [PW-1:0] wr_p2;

    assign frame_evt = enable & active_p1 & fs_p1;
    assign warm_inc  = warm_cnt + 1'b1;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_warm  = warm_cnt;
        if (frame_evt) begin
            if (load_p1 || load_pend) begin
                next_state = S_COPY;
                next_warm  = '0;
            end else begin
                case (state)
                    S_IDLE: next_state = S_COPY;
                    S_COPY: begin
                        next_state = (WARMUP_FRAMES == 0) ? S_RUN : S_WARM;
                        next_warm  = '0;
                    end
                    S_WARM: begin
                        next_warm = warm_inc;
                        if (warm_inc >= WC_W'(WARMUP_FRAMES)) next_state = S_RUN;
                    end
                    S_RUN:
                        if (limit_p1 != '0 && fg_cnt > limit_p1) next_state = S_RELEARN;
                    S_RELEARN: next_state = S_RUN;
                    default: next_state = S_IDLE;
                endcase
            end
        end
    end

    // Per-channel signed difference and magnitude, evaluated on the p1 contents.
    assign abs_sum[0] = '0;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_cmp
        logic [PIXEL_WIDTH-1:0] lv, bv, mag;
        logic signed [DW-1:0]   d, nd;
        assign lv = live_p1[c*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign bv = bg_p1[c*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign d  = $signed({1'b0, lv}) - $signed({1'b0, bv});
        assign nd = -d;
        assign mag = d[DW-1] ? nd[PIXEL_WIDTH-1:0] : d[PIXEL_WIDTH-1:0];
        assign over_thr[c]    = {2'b00, mag} > thr_p1;
        assign abs_sum[c+1]   = abs_sum[c] + {2'b00, mag};
        assign diff_p1[c*DW +: DW] = d;
    end

    assign fg_raw = mode_p1 ? (abs_sum[NUM_CH] > thr_p1) : (|over_thr);
    // The frame-start pixel already sees the state it opens.
    assign fg_p1  = fg_raw & (next_state == S_RUN) & active_p1;

    // Background update per channel, evaluated on the p2 contents.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_upd
        logic [PIXEL_WIDTH-1:0]     lv, bv, sat;
        logic signed [DW-1:0]       d, sh;
        logic signed [DW:0]         sum;
        assign lv  = live_p2[c*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign bv  = bg_p2[c*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign d   = $signed(diff_p2[c*DW +: DW]);
        assign sh  = (state_p2 == S_RUN) ? (fg_p2 ? (d >>> FG_SHIFT_LG2) : (d >>> SHIFT_LG2))
                                         : (d >>> WARM_SHIFT_LG2);
        assign sum = $signed({2'b00, bv}) + $signed({sh[DW-1], sh});
        assign sat = sum[DW] ? '0 : (sum[DW-1] ? '1 : sum[PIXEL_WIDTH-1:0]);
        assign wr_p2[c*PIXEL_WIDTH +: PIXEL_WIDTH] =
            (state_p2 == S_COPY) ? lv : ((state_p2 == S_IDLE) ? bv : sat);
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            warm_cnt       <= '0;
            fg_cnt         <= '0;
            load_pend      <= 1'b0;
            fg_count_out   <= '0;
            fg_count_valid <= 1'b0;
            addr_p1   <= '0;  live_p1 <= '0;  bg_p1  <= '0;
            active_p1 <= 1'b0; fs_p1  <= 1'b0; load_p1 <= 1'b0;
            mode_p1   <= 1'b0; thr_p1 <= '0;  limit_p1 <= '0;
            addr_p2   <= '0;  live_p2 <= '0;  bg_p2  <= '0;  diff_p2 <= '0;
            active_p2 <= 1'b0; fg_p2  <= 1'b0; state_p2 <= S_IDLE;
            bg_wr_addr      <= '0;
            bg_wr_data      <= '0;
            en_p3           <= 1'b0;
            fg_pixel_out    <= '0;
            foreground_flag <= 1'b0;
            out_valid       <= 1'b0;
        end else if (enable) begin
            state    <= next_state;
            warm_cnt <= next_warm;

            // A load request seen mid-frame is held until the next frame start.
            if (frame_evt)    load_pend <= 1'b0;
            else if (load_p1) load_pend <= 1'b1;

            if (frame_evt) begin
                fg_count_out   <= fg_cnt;
                fg_count_valid <= 1'b1;
                fg_cnt         <= CNT_W'(fg_p1);
            end else begin
                fg_count_valid <= 1'b0;
                if (fg_p1 && fg_cnt != '1) fg_cnt <= fg_cnt + 1'b1;
            end

            addr_p1   <= addr_in;
            live_p1   <= live_pixel_in;
            bg_p1     <= bg_pixel_in;
            active_p1 <= active_in;
            fs_p1     <= frame_start_in;
            load_p1   <= load_frame;
            mode_p1   <= fg_mode_in;
            thr_p1    <= threshold_in;
            limit_p1  <= global_limit_in;

            addr_p2   <= addr_p1;
            live_p2   <= live_p1;
            bg_p2     <= bg_p1;
            diff_p2   <= diff_p1;
            active_p2 <= active_p1;
            fg_p2     <= fg_p1;
            state_p2  <= next_state;

            out_valid       <= active_p2;
            en_p3           <= active_p2 & (state_p2 != S_IDLE);
            bg_wr_addr      <= active_p2 ? addr_p2 : '0;
            bg_wr_data      <= active_p2 ? wr_p2 : '0;
            foreground_flag <= fg_p2;
            fg_pixel_out    <= fg_p2 ? live_p2 : '0;
        end
    end

    // Gating with enable keeps a stalled write from being issued twice.
    assign bg_wr_en  = en_p3 & enable;
    assign state_out = state;

endmodule

// File: tb/tb_adaptive_background_mc.sv
// Directed bench for adaptive_background_mc: frame sequencing through COPY/WARM/RUN/RELEARN,
// update arithmetic, foreground count, load request, stall and mid-frame reset.
module tb_adaptive_background_mc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [16:0] addr_in;
    logic [23:0] live_pixel_in, bg_pixel_in;
    logic        active_in, frame_start_in, load_frame, fg_mode_in;
    logic [9:0]  threshold_in;
    logic [17:0] global_limit_in;
    logic [16:0] bg_wr_addr;
    logic [23:0] bg_wr_data, fg_pixel_out;
    logic        bg_wr_en, foreground_flag, out_valid, fg_count_valid;
    logic [17:0] fg_count_out;
    logic [2:0]  state_out;

    int n_assert = 0;
    int n_fail   = 0;
    logic [16:0] addr_ctr = '0;
    logic        mid_valid;
    logic [17:0] mid_cnt;

    adaptive_background_mc dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .addr_in(addr_in),
        .live_pixel_in(live_pixel_in), .bg_pixel_in(bg_pixel_in),
        .active_in(active_in), .frame_start_in(frame_start_in),
        .load_frame(load_frame), .fg_mode_in(fg_mode_in),
        .threshold_in(threshold_in), .global_limit_in(global_limit_in),
        .bg_wr_addr(bg_wr_addr), .bg_wr_data(bg_wr_data), .bg_wr_en(bg_wr_en),
        .fg_pixel_out(fg_pixel_out), .foreground_flag(foreground_flag),
        .out_valid(out_valid), .fg_count_out(fg_count_out),
        .fg_count_valid(fg_count_valid), .state_out(state_out)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rep(input logic [7:0] v);
        return {3{v}};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel through the pipeline; returns with its results on the outputs.
    // mid_valid/mid_cnt capture the count outputs on the cycle the frame-start event lands.
    task automatic send(input logic [23:0] live, input logic [23:0] bg, input logic fs);
        @(negedge clk);
        addr_in        = addr_ctr;
        live_pixel_in  = live;
        bg_pixel_in    = bg;
        active_in      = 1'b1;
        frame_start_in = fs;
        @(posedge clk);
        @(negedge clk);
        active_in      = 1'b0;
        frame_start_in = 1'b0;
        @(posedge clk);
        #1;
        mid_valid = fg_count_valid;
        mid_cnt   = fg_count_out;
        @(posedge clk);
        #1;
        addr_ctr = addr_ctr + 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; addr_in = '0; live_pixel_in = '0; bg_pixel_in = '0;
        active_in = 1'b0; frame_start_in = 1'b0; load_frame = 1'b0; fg_mode_in = 1'b0;
        threshold_in = 10'h020; global_limit_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_wr_en", bg_wr_en, 0);
        check("rst_count", fg_count_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 0: IDLE -> COPY, background takes the live pixel.
        send(24'h302010, 24'h000000, 1'b1);
        check("copy_state", state_out, 1);
        check("copy_wr_en", bg_wr_en, 1);
        check("copy_data", bg_wr_data, 24'h302010);
        check("copy_addr", bg_wr_addr, 0);
        check("copy_fg", foreground_flag, 0);
        check("copy_valid", out_valid, 1);
        send(24'h0a0b0c, 24'h111111, 1'b0);
        check("copy_data2", bg_wr_data, 24'h0a0b0c);

        // Eight WARM frames at rate 1/2.
        for (int k = 0; k < 8; k++) begin
            send(rep(8'h80), rep(8'h40), 1'b1);
            if (k == 0) begin
                check("warm_state", state_out, 2);
                check("warm_data", bg_wr_data, 24'h606060);
                check("warm_fg", foreground_flag, 0);
            end
        end
        check("warm_state_end", state_out, 2);

        // RUN frame: floor of negative update, foreground decisions.
        send(rep(8'h00), rep(8'h03), 1'b1);
        check("run_state", state_out, 3);
        check("run_floor", bg_wr_data, 24'h020202);
        check("run_floor_fg", foreground_flag, 0);
        send(24'h609060, rep(8'h60), 1'b0);
        check("run_m0_fg", foreground_flag, 1);
        check("run_m0_pix", fg_pixel_out, 24'h609060);
        check("run_m0_data", bg_wr_data, 24'h606060);
        send(rep(8'hFF), rep(8'hFE), 1'b0);
        check("run_top", bg_wr_data, 24'hFEFEFE);
        check("run_top_pix", fg_pixel_out, 0);
        send(rep(8'h00), rep(8'h01), 1'b0);
        check("run_zero", bg_wr_data, 24'h000000);
        fg_mode_in = 1'b1;
        send(rep(8'h4C), rep(8'h40), 1'b0);
        check("run_m1_fg", foreground_flag, 1);
        check("run_m1_data", bg_wr_data, 24'h404040);
        fg_mode_in = 1'b0;
        send(rep(8'h4C), rep(8'h40), 1'b0);
        check("run_m0_nofg", foreground_flag, 0);
        check("run_m0_slow", bg_wr_data, 24'h414141);
        send(rep(8'h00), rep(8'h80), 1'b0);
        check("run_neg_fg", foreground_flag, 1);
        check("run_neg_data", bg_wr_data, 24'h7F7F7F);

        // Frame with 11 foreground pixels against a limit of 10.
        global_limit_in = 18'd10;
        for (int k = 0; k < 11; k++) begin
            send(rep(8'hFF), rep(8'h00), (k == 0));
            if (k == 0) begin
                check("cnt_prev_valid", mid_valid, 1);
                check("cnt_prev", mid_cnt, 3);
                check("cnt_state_run", state_out, 3);
            end
        end
        check("fg_full_data", bg_wr_data, 24'h010101);
        check("fg_full_pix", fg_pixel_out, 24'hFFFFFF);

        send(rep(8'h80), rep(8'h40), 1'b1);
        check("relearn_pulse", mid_valid, 1);
        check("relearn_cnt", mid_cnt, 11);
        check("relearn_state", state_out, 4);
        check("relearn_data", bg_wr_data, 24'h606060);
        check("relearn_fg", foreground_flag, 0);
        check("relearn_pulse_end", fg_count_valid, 0);
        send(rep(8'hFF), rep(8'h00), 1'b0);
        check("relearn_data2", bg_wr_data, 24'h7F7F7F);
        check("relearn_fg2", foreground_flag, 0);

        send(rep(8'h80), rep(8'h40), 1'b1);
        check("back_run", state_out, 3);
        check("back_run_cnt", mid_cnt, 0);
        check("back_run_fg", foreground_flag, 1);
        check("back_run_data", bg_wr_data, 24'h404040);

        // Load request mid-frame waits for the next frame start.
        load_frame = 1'b1;
        send(rep(8'h10), rep(8'h10), 1'b0);
        load_frame = 1'b0;
        check("load_mid_state", state_out, 3);
        send(rep(8'h10), rep(8'h10), 1'b0);
        check("load_mid_state2", state_out, 3);
        send(24'h654321, rep(8'h10), 1'b1);
        check("load_copy_state", state_out, 1);
        check("load_copy_data", bg_wr_data, 24'h654321);

        // Stall: outputs freeze, no write strobe, pixel offered during stall is not taken.
        send(24'h123456, 24'h000000, 1'b0);
        check("pre_stall_wr_en", bg_wr_en, 1);
        @(negedge clk);
        enable = 1'b0;
        live_pixel_in = 24'hABCDEF; active_in = 1'b1;
        #1;
        check("stall_wr_en_now", bg_wr_en, 0);
        repeat (5) @(posedge clk);
        #1;
        check("stall_wr_en", bg_wr_en, 0);
        check("stall_data", bg_wr_data, 24'h123456);
        check("stall_valid", out_valid, 1);
        @(negedge clk);
        active_in = 1'b0;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_stall_valid", out_valid, 0);
        check("post_stall_wr_en", bg_wr_en, 0);

        // Reset mid-frame.
        send(rep(8'h11), rep(8'h00), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_state", state_out, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_data", bg_wr_data, 0);
        check("mrst_wr_en", bg_wr_en, 0);
        check("mrst_count", fg_count_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(rep(8'h22), rep(8'h05), 1'b0);
        check("idle_valid", out_valid, 1);
        check("idle_no_write", bg_wr_en, 0);
        check("idle_state", state_out, 0);
        send(rep(8'h22), rep(8'h05), 1'b1);
        check("restart_state", state_out, 1);
        check("restart_wr_en", bg_wr_en, 1);
        check("restart_data", bg_wr_data, 24'h222222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
